// File: rtl/jtkunio_pkg.sv
// jtkunio_pkg
// Shared definitions for the Kunio video section.
//   GFX_SCR/GFX_CHR/GFX_OBJ : client ids used in the upper bits of the
//                             shared graphics ROM address
//   gfx_state_t             : graphics ROM arbiter sequencer states
package jtkunio_pkg;

  localparam logic [1:0] GFX_SCR = 2'd0;
  localparam logic [1:0] GFX_CHR = 2'd1;
  localparam logic [1:0] GFX_OBJ = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } gfx_state_t;

endpackage

// File: rtl/jtkunio_gfx_slot.sv
// jtkunio_gfx_slot
// One client's single-entry ROM cache: tag, valid bit and data word.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cs, addr          client request enable and word address
//   wr, wr_tag,       fill strobe from the arbiter, the address that was
//   wr_data           actually fetched and the returned data
//   data              cached data word
//   ok                cached word matches the current client address
//   pending           client wants data that is not cached
module jtkunio_gfx_slot
  import jtkunio_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic [31:0]   data,
  output logic          ok,
  output logic          pending
);

  logic [AW-1:0] tag;
  logic          valid;

  // The tag is the address latched at grant time, not the live client
  // address, so a client that moved on during the fetch still misses.
  // The valid bit only ever gets set; freshness is decided by the tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      valid <= 1'b0;
      data  <= '0;
    end else if (wr) begin
      tag   <= wr_tag;
      valid <= 1'b1;
      data  <= wr_data;
    end
  end

  assign ok      = cs & valid & (addr == tag);
  assign pending = cs & ~ok;

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// jtkunio_gfx_arb
// Shares the single graphics ROM SDRAM slot between the scroll, character
// and object fetchers. Each client sees a private cached port.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   scr_/chr_/obj_addr, _cs        client word address and request enable
//   scr_/chr_/obj_data, _ok        cached data and hit flag per client
//   rom_addr                       {client id, word address} to SDRAM
//   rom_cs                         shared request, high in REQ and WAIT
//   rom_data, rom_ok               SDRAM answer
// Optional feature: define JTKUNIO_ARB_TIMEOUT_EN to abandon a fetch after
// TOUT cycles in WAIT without rom_ok; the client is then retried.
module jtkunio_gfx_arb
  import jtkunio_pkg::*;
#(
  parameter int AW     = 17,
  parameter int STARVE = 4,
  parameter int TOUT   = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] scr_addr,
  input  logic [AW-1:0] chr_addr,
  input  logic [AW-1:0] obj_addr,
  input  logic          scr_cs,
  input  logic          chr_cs,
  input  logic          obj_cs,
  output logic [31:0]   scr_data,
  output logic [31:0]   chr_data,
  output logic [31:0]   obj_data,
  output logic          scr_ok,
  output logic          chr_ok,
  output logic          obj_ok,
  output logic [AW+1:0] rom_addr,
  output logic          rom_cs,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok
);

  gfx_state_t    state, state_nxt;
  logic [2:0]    starve_cnt;
  logic [2:0]    pend;
  logic [2:0]    wr_en;
  logic [1:0]    win_id;
  logic [AW-1:0] win_addr;
  logic          any_pend;
  logic          tout_hit;

  jtkunio_gfx_slot #(.AW(AW)) u_scr (
    .clk(clk), .rst_n(rst_n), .cs(scr_cs), .addr(scr_addr),
    .wr(wr_en[GFX_SCR]), .wr_tag(rom_addr[AW-1:0]), .wr_data(rom_data),
    .data(scr_data), .ok(scr_ok), .pending(pend[GFX_SCR])
  );

  jtkunio_gfx_slot #(.AW(AW)) u_chr (
    .clk(clk), .rst_n(rst_n), .cs(chr_cs), .addr(chr_addr),
    .wr(wr_en[GFX_CHR]), .wr_tag(rom_addr[AW-1:0]), .wr_data(rom_data),
    .data(chr_data), .ok(chr_ok), .pending(pend[GFX_CHR])
  );

  jtkunio_gfx_slot #(.AW(AW)) u_obj (
    .clk(clk), .rst_n(rst_n), .cs(obj_cs), .addr(obj_addr),
    .wr(wr_en[GFX_OBJ]), .wr_tag(rom_addr[AW-1:0]), .wr_data(rom_data),
    .data(obj_data), .ok(obj_ok), .pending(pend[GFX_OBJ])
  );

  assign any_pend = |pend;

  // Fixed priority scroll > char > object, except that an object client
  // that has watched STARVE higher-priority grants go by wins outright.
  always_comb begin
    win_id   = GFX_SCR;
    win_addr = scr_addr;
    if (pend[GFX_OBJ] && (starve_cnt >= 3'(STARVE))) begin
      win_id = GFX_OBJ;
    end else if (pend[GFX_SCR]) begin
      win_id = GFX_SCR;
    end else if (pend[GFX_CHR]) begin
      win_id = GFX_CHR;
    end else begin
      win_id = GFX_OBJ;
    end
    case (win_id)
      GFX_CHR: win_addr = chr_addr;
      GFX_OBJ: win_addr = obj_addr;
      default: win_addr = scr_addr;
    endcase
  end

`ifdef JTKUNIO_ARB_TIMEOUT_EN
  logic [5:0] tout_cnt;

  // Counts WAIT cycles without an answer; cleared outside WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tout_cnt <= '0;
    end else if (state == WAIT && !rom_ok) begin
      tout_cnt <= tout_cnt + 6'd1;
    end else begin
      tout_cnt <= '0;
    end
  end

  assign tout_hit = (tout_cnt == 6'(TOUT - 1));
`else
  assign tout_hit = 1'b0;
`endif

  // rom_ok during REQ may belong to a previous access, so only WAIT
  // accepts it. The fill goes to the client whose id sits in rom_addr.
  always_comb begin
    state_nxt = state;
    rom_cs    = 1'b0;
    wr_en     = 3'b000;
    case (state)
      IDLE: if (any_pend) state_nxt = REQ;
      REQ: begin
        rom_cs    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        rom_cs = 1'b1;
        if (rom_ok) begin
          wr_en     = 3'b001 << rom_addr[AW+1:AW];
          state_nxt = DONE;
        end else if (tout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  // rom_addr only changes at a grant, so it holds through REQ and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_pend) begin
        rom_addr <= {win_id, win_addr};
        if (win_id == GFX_OBJ) begin
          starve_cnt <= '0;
        end else if (pend[GFX_OBJ]) begin
          starve_cnt <= starve_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// tb_jtkunio_gfx_arb
// Directed checks of reset, single fetch latency, starvation guard,
// address change mid-fetch, timeout / endless WAIT and asynchronous reset,
// followed by a randomized run against a transaction-level cache model.
// Optional feature: JTKUNIO_ARB_TIMEOUT_EN selects the timeout expectations.
module tb_jtkunio_gfx_arb;

  localparam int AW     = 17;
  localparam int STARVE = 4;
  localparam int TOUT   = 63;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] scr_addr = '0, chr_addr = '0, obj_addr = '0;
  logic          scr_cs = 1'b0, chr_cs = 1'b0, obj_cs = 1'b0;
  logic [31:0]   scr_data, chr_data, obj_data;
  logic          scr_ok, chr_ok, obj_ok;
  logic [AW+1:0] rom_addr;
  logic          rom_cs;
  logic [31:0]   rom_data = '0;
  logic          rom_ok = 1'b0;

  int tests_run = 0;
  int failed    = 0;
  int age       = -1;
  bit rose      = 1'b0;

  always #5 clk = ~clk;

  jtkunio_gfx_arb #(.AW(AW), .STARVE(STARVE), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .scr_addr(scr_addr), .chr_addr(chr_addr), .obj_addr(obj_addr),
    .scr_cs(scr_cs), .chr_cs(chr_cs), .obj_cs(obj_cs),
    .scr_data(scr_data), .chr_data(chr_data), .obj_data(obj_data),
    .scr_ok(scr_ok), .chr_ok(chr_ok), .obj_ok(obj_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok)
  );

  function automatic logic [31:0] rom_word(input logic [AW+1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5AF00D;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, track the request age and, when
  // asked, answer any request in its first WAIT cycle.
  task automatic applyStimulus(input bit respond);
    @(posedge clk);
    #1;
    rose = 1'b0;
    if (rom_cs) begin
      if (age < 0) begin
        age  = 0;
        rose = 1'b1;
      end else begin
        age++;
      end
    end else begin
      age = -1;
    end
    if (respond && rom_cs && age >= 1) begin
      rom_ok   = 1'b1;
      rom_data = rom_word(rom_addr);
    end else begin
      rom_ok   = 1'b0;
      rom_data = 32'h0;
    end
  endtask

  task automatic doReset();
    rom_ok = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    age   = -1;
  endtask

  // randomized-phase model state
  logic          m_valid[3];
  logic [AW-1:0] m_tag[3];
  logic [31:0]   m_data[3];
  logic          cs_v[3];
  logic [AW-1:0] addr_v[3];
  logic          snap_pend[3];
  logic [AW-1:0] snap_addr[3];

  initial begin
    int arb, wait_cnt, phase, starve, exp_id;
    bit got_obj, hold, acc, snap_any, m_ok;
    logic [AW+1:0] grant_addr;
    logic [31:0]   obs_data;
    logic          obs_ok;

    // reset state with all clients requesting
    scr_cs = 1; chr_cs = 1; obj_cs = 1;
    scr_addr = 17'h00123; chr_addr = 17'h00040; obj_addr = 17'h00050;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rst_rom_cs", rom_cs, 0);
    end
    checkOutput("rst_rom_addr", rom_addr, 0);
    checkOutput("rst_oks", {scr_ok, chr_ok, obj_ok}, 0);
    checkOutput("rst_scr_data", scr_data, 0);
    #2;
    rst_n = 1'b1;

    // single fetch, answered in the first WAIT cycle
    applyStimulus(0);
    checkOutput("first_grant_cs", rom_cs, 1);
    checkOutput("first_grant_addr", rom_addr, {2'd0, 17'h00123});
    applyStimulus(0);
    checkOutput("wait_cs", rom_cs, 1);
    checkOutput("wait_scr_ok", scr_ok, 0);
    rom_ok = 1'b1;
    rom_data = 32'hDEADBEEF;
    applyStimulus(0);
    checkOutput("fetch_scr_ok", scr_ok, 1);
    checkOutput("fetch_scr_data", scr_data, 32'hDEADBEEF);
    checkOutput("done_cs", rom_cs, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      if (rose) checkOutput("no_scr_rereq", rom_addr[AW+1:AW] == 2'd0, 0);
      checkOutput("scr_ok_holds", scr_ok, 1);
    end
    checkOutput("chr_served", {chr_ok, chr_data}, {1'b1, rom_word({2'd1, 17'h00040})});
    checkOutput("obj_served", {obj_ok, obj_data}, {1'b1, rom_word({2'd2, 17'h00050})});

    // starvation guard
    scr_addr = 17'h1; chr_addr = 17'h2; obj_addr = 17'h3;
    doReset();
    arb = 0;
    got_obj = 0;
    for (int i = 0; i < 100 && !got_obj; i++) begin
      applyStimulus(1);
      if (rose) begin
        arb++;
        if (rom_addr[AW+1:AW] == 2'd2) begin
          got_obj = 1;
          checkOutput("starve_obj_addr", rom_addr, {2'd2, 17'h3});
        end
      end
      if (!rom_cs) begin
        scr_addr = scr_addr + 17'd4;
        chr_addr = chr_addr + 17'd4;
      end
    end
    checkOutput("starve_obj_granted", got_obj, 1);
    checkOutput("starve_arb_le5", arb <= 5, 1);

    // address change during WAIT
    scr_cs = 0; obj_cs = 0; chr_cs = 1; chr_addr = 17'h10;
    doReset();
    applyStimulus(0);
    checkOutput("chg_grant", rom_addr, {2'd1, 17'h10});
    applyStimulus(0);
    chr_addr = 17'h11;
    rom_ok = 1'b1;
    rom_data = 32'hCAFE0010;
    applyStimulus(0);
    checkOutput("chg_data", chr_data, 32'hCAFE0010);
    checkOutput("chg_ok_low", chr_ok, 0);
    chr_addr = 17'h10;
    #1;
    checkOutput("chg_tag_old", chr_ok, 1);
    chr_addr = 17'h11;
    applyStimulus(0);
    checkOutput("chg_idle_gap", rom_cs, 0);
    applyStimulus(0);
    checkOutput("chg_rereq_cs", rom_cs, 1);
    checkOutput("chg_rereq_addr", rom_addr, {2'd1, 17'h11});

    // unanswered request, then asynchronous reset in WAIT
    scr_cs = 0; obj_cs = 0; chr_cs = 1; chr_addr = 17'h21;
    doReset();
    for (int i = 0; i < 20 && !chr_ok; i++) applyStimulus(1);
    checkOutput("to_chr_ready", chr_ok, 1);
    scr_cs = 1;
    scr_addr = 17'h7;
    for (int i = 0; i < 10 && !rose; i++) applyStimulus(0);
    checkOutput("to_grant", rom_addr, {2'd0, 17'h7});
`ifdef JTKUNIO_ARB_TIMEOUT_EN
    wait_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0);
      if (!rom_cs) break;
      wait_cnt++;
    end
    checkOutput("to_wait_cycles", wait_cnt, TOUT);
    checkOutput("to_scr_ok", scr_ok, 0);
    applyStimulus(0);
    checkOutput("to_idle", rom_cs, 0);
    applyStimulus(0);
    checkOutput("to_retry_cs", rom_cs, 1);
    checkOutput("to_retry_addr", rom_addr, {2'd0, 17'h7});
    applyStimulus(0);
`else
    hold = 1;
    repeat (150) begin
      applyStimulus(0);
      if (!rom_cs) hold = 0;
    end
    checkOutput("wait_forever", hold, 1);
    checkOutput("wait_scr_ok", scr_ok, 0);
`endif
    checkOutput("pre_areset_chr_ok", chr_ok, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_rom_cs", rom_cs, 0);
    checkOutput("areset_oks", {scr_ok, chr_ok, obj_ok}, 0);
    checkOutput("areset_chr_data", chr_data, 0);

    // randomized run against the cache model
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
      cs_v[i]    = 1'($urandom_range(0, 1));
      addr_v[i]  = AW'($urandom_range(0, 3));
    end
    {scr_cs, chr_cs, obj_cs} = {cs_v[0], cs_v[1], cs_v[2]};
    {scr_addr, chr_addr, obj_addr} = {addr_v[0], addr_v[1], addr_v[2]};
    snap_any = 0;
    for (int i = 0; i < 3; i++) begin
      snap_pend[i] = cs_v[i];
      snap_addr[i] = addr_v[i];
      snap_any |= cs_v[i];
    end
    phase = 0; starve = 0; acc = 0; age = 0; grant_addr = '0;
    rom_ok = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (acc) begin
        m_valid[grant_addr[AW+1:AW]] = 1;
        m_tag[grant_addr[AW+1:AW]]   = grant_addr[AW-1:0];
        m_data[grant_addr[AW+1:AW]]  = rom_word(grant_addr);
      end
      case (phase)
        0: begin
          if (snap_any) begin
            checkOutput("rnd_req", rom_cs, 1);
            if (snap_pend[2] && starve >= STARVE) exp_id = 2;
            else if (snap_pend[0]) exp_id = 0;
            else if (snap_pend[1]) exp_id = 1;
            else exp_id = 2;
            grant_addr = {2'(exp_id), snap_addr[exp_id]};
            checkOutput("rnd_grant", rom_addr, grant_addr);
            if (exp_id == 2) starve = 0;
            else if (snap_pend[2]) starve++;
            phase = 1;
            age = 0;
          end else begin
            checkOutput("rnd_idle", rom_cs, 0);
          end
        end
        1: begin
          if (acc) begin
            checkOutput("rnd_done", rom_cs, 0);
            phase = 2;
          end else begin
            checkOutput("rnd_hold", rom_cs, 1);
            checkOutput("rnd_addr_stable", rom_addr, grant_addr);
            age++;
          end
        end
        default: begin
          checkOutput("rnd_gap", rom_cs, 0);
          phase = 0;
        end
      endcase
      for (int i = 0; i < 3; i++) begin
        m_ok = cs_v[i] && m_valid[i] && (m_tag[i] == addr_v[i]);
        case (i)
          0: begin obs_ok = scr_ok; obs_data = scr_data; end
          1: begin obs_ok = chr_ok; obs_data = chr_data; end
          default: begin obs_ok = obj_ok; obs_data = obj_data; end
        endcase
        checkOutput($sformatf("rnd_ok%0d", i), obs_ok, m_ok);
        checkOutput($sformatf("rnd_data%0d", i), obs_data, m_data[i]);
      end
      snap_any = 0;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 7) == 0) cs_v[i] = ~cs_v[i];
        if ($urandom_range(0, 5) == 0) addr_v[i] = AW'($urandom_range(0, 3));
        snap_pend[i] = cs_v[i] && !(m_valid[i] && (m_tag[i] == addr_v[i]));
        snap_addr[i] = addr_v[i];
        snap_any |= snap_pend[i];
      end
      {scr_cs, chr_cs, obj_cs} = {cs_v[0], cs_v[1], cs_v[2]};
      {scr_addr, chr_addr, obj_addr} = {addr_v[0], addr_v[1], addr_v[2]};
      acc = 0;
      rom_ok = 1'b0;
      rom_data = $urandom;
      if (phase == 1 && age == 0 && $urandom_range(0, 1) == 1) rom_ok = 1'b1;
      if (phase == 1 && age >= 1 && ($urandom_range(0, 2) == 0 || age >= 20)) begin
        acc = 1;
        rom_ok = 1'b1;
        rom_data = rom_word(grant_addr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
